// File: rtl/eth_transmitter.sv
// Frame transmitter: fetches bytes from an asynchronous SRAM and shifts them out
// LSB first on a 4-cycle-per-bit serial link (sck/sda). All outputs are registered.
module eth_transmitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] base,
    input  logic [10:0] len,
    output logic [10:0] a,
    input  logic [7:0]  d,
    output logic        n_cs,
    output logic        n_oe,
    output logic        sck,
    output logic        sda,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        SHIFT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] a_q, a_d;
    logic [10:0] rem_q, rem_d;
    logic [6:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  phase_q, phase_d;
    logic        n_cs_q, n_cs_d;
    logic        n_oe_q, n_oe_d;
    logic        sck_q, sck_d;
    logic        sda_q, sda_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 11'd0;
            rem_q   <= 11'd0;
            sh_q    <= 7'd0;
            bit_q   <= 3'd0;
            phase_q <= 2'd0;
            n_cs_q  <= 1'b1;
            n_oe_q  <= 1'b1;
            sck_q   <= 1'b0;
            sda_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            n_cs_q  <= n_cs_d;
            n_oe_q  <= n_oe_d;
            sck_q   <= sck_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        n_cs_d  = n_cs_q;
        n_oe_d  = n_oe_q;
        sck_d   = sck_q;
        sda_d   = sda_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the cycle a frame just ended; a start there is dropped
                if (start && !done_q && (len != 11'd0)) begin
                    state_d = FETCH1;
                    a_d     = base;
                    rem_d   = len;
                    n_cs_d  = 1'b0;
                    n_oe_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (start && !done_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            FETCH1: begin
                state_d = FETCH2;
            end
            FETCH2: begin
                state_d = SHIFT;
                sh_d    = d[7:1];
                sda_d   = d[0];
                n_cs_d  = 1'b1;
                n_oe_d  = 1'b1;
                bit_d   = 3'd0;
                phase_d = 2'd0;
                sck_d   = 1'b0;
            end
            SHIFT: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    sck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        sda_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[6:1]};
                    end else if (rem_q > 11'd1) begin
                        rem_d   = rem_q - 11'd1;
                        a_d     = a_q + 11'd1;
                        state_d = FETCH1;
                        n_cs_d  = 1'b0;
                        n_oe_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        sda_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    // entering phase 2 or 3 raises sck
                    sck_d = (phase_q != 2'd0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a    = a_q;
    assign n_cs = n_cs_q;
    assign n_oe = n_oe_q;
    assign sck  = sck_q;
    assign sda  = sda_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_eth_transmitter.sv
// Randomized bench for eth_transmitter: an SRAM array feeds the DUT, a monitor
// decodes the serial link and a frame-level reference model checks each frame.
module tb_eth_transmitter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] base;
    logic [10:0] len;
    logic [10:0] a;
    logic [7:0]  d;
    logic        n_cs;
    logic        n_oe;
    logic        sck;
    logic        sda;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:2047];

    int n_tests;
    int n_fail;

    // monitor state
    int cyc;
    int ncs_cnt, oe_err, sck_rises, done_cnt, busy_cnt, f1_cyc, done_cyc, stab_err, hold_err;
    logic [10:0] addr_q [$];
    logic        bits_q [$];
    logic        prev_sck, sda_p1, sda_p2;

    eth_transmitter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .base (base),
        .len  (len),
        .a    (a),
        .d    (d),
        .n_cs (n_cs),
        .n_oe (n_oe),
        .sck  (sck),
        .sda  (sda),
        .busy (busy),
        .done (done)
    );

    assign d = mem[a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        ncs_cnt   = 0;
        oe_err    = 0;
        sck_rises = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        f1_cyc    = 0;
        done_cyc  = 0;
        stab_err  = 0;
        hold_err  = 0;
        addr_q.delete();
        bits_q.delete();
    endtask

    // Link/SRAM monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (n_oe !== n_cs) oe_err++;
            if (!n_cs) begin
                if (ncs_cnt == 0) f1_cyc = cyc;
                ncs_cnt++;
                addr_q.push_back(a);
                if (bits_q.size() > 0 && sda !== bits_q[$]) hold_err++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sck && !prev_sck) begin
                sck_rises++;
                bits_q.push_back(sda);
                if (sda !== sda_p1 || sda !== sda_p2) stab_err++;
            end else if (sck && sda !== sda_p1) begin
                stab_err++;
            end
        end
        prev_sck = sck;
        sda_p2   = sda_p1;
        sda_p1   = sda;
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_a"},    int'(a),    0);
        check_eq({tag, "_ncs"},  int'(n_cs), 1);
        check_eq({tag, "_noe"},  int'(n_oe), 1);
        check_eq({tag, "_sck"},  int'(sck),  0);
        check_eq({tag, "_sda"},  int'(sda),  0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
    endtask

    // Reference model: a frame of l bytes reads base+i (mod 2048) twice each,
    // emits each byte LSB first and takes 34 cycles per byte.
    task automatic check_frame(input logic [10:0] b, input int l);
        logic [10:0] exp_a;
        logic [7:0]  got_byte;
        check_eq("done_count",  done_cnt,  1);
        check_eq("ncs_cycles",  ncs_cnt,   2 * l);
        check_eq("noe_vs_ncs",  oe_err,    0);
        check_eq("sck_rises",   sck_rises, 8 * l);
        check_eq("busy_cycles", busy_cnt,  34 * l);
        check_eq("sda_stable",  stab_err,  0);
        check_eq("sda_hold",    hold_err,  0);
        if (l > 0) check_eq("frame_cycles", done_cyc - f1_cyc, 34 * l);
        for (int i = 0; i < l; i++) begin
            exp_a = 11'((int'(b) + i) % 2048);
            if (addr_q.size() >= 2 * i + 2) begin
                check_eq("addr_first",  int'(addr_q[2 * i]),     int'(exp_a));
                check_eq("addr_second", int'(addr_q[2 * i + 1]), int'(exp_a));
            end
            if (bits_q.size() >= 8 * i + 8) begin
                for (int j = 0; j < 8; j++) got_byte[j] = bits_q[8 * i + j];
                check_eq("byte", int'(got_byte), int'(mem[exp_a]));
            end
        end
    endtask

    task automatic run_frame(input logic [10:0] b, input int l, input bit restart_mid, input bit start_at_done);
        int k;
        int budget;
        budget = 34 * l + 40;
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        base  = b;
        len   = 11'(l);
        @(posedge clk); #1;
        start = 1'b0;
        base  = 11'($urandom);
        len   = 11'($urandom);
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (restart_mid && (k == 20 || k == 40)) begin
                start = 1'b1;
                base  = 11'($urandom);
                len   = 11'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
        end
        check_eq("done_seen", int'(done), 1);
        if (start_at_done) begin
            start = 1'b1;
            base  = 11'($urandom);
            len   = 11'd1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
        if (start_at_done) check_eq("busy_after_done_start", int'(busy), 0);
        check_frame(b, l);
    endtask

    initial begin
        int k;
        logic [7:0] seq7 [0:6];
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        prev_sck = 1'b0;
        sda_p1   = 1'b0;
        sda_p2   = 1'b0;
        clear_mon();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        start = 1'b0;
        base  = 11'd0;
        len   = 11'd0;
        rst   = 1'b1;
        #2;
        check_reset_outputs("reset0");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // single byte 0x10
        mem[0] = 8'h10;
        run_frame(11'd0, 1, 1'b0, 1'b0);

        // seven-byte frame
        seq7 = '{8'h10, 8'hd5, 8'h20, 8'hff, 8'h00, 8'ha5, 8'h73};
        for (int i = 0; i < 7; i++) mem[i] = seq7[i];
        run_frame(11'd0, 7, 1'b0, 1'b0);

        // address wrap
        run_frame(11'd2046, 3, 1'b0, 1'b0);

        // zero-length request
        run_frame(11'd500, 0, 1'b0, 1'b0);

        // start pulses while busy
        run_frame(11'($urandom), 2, 1'b1, 1'b0);

        // start coinciding with done
        run_frame(11'($urandom), 2, 1'b0, 1'b1);

        // reset in the middle of bit 3 of byte 2
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        base  = 11'd100;
        len   = 11'd3;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (sck_rises < 12 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("reached_byte2_bit3", sck_rises, 12);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", done_cnt, 0);
        check_eq("idle_after_abort", int'(busy), 0);
        run_frame(11'($urandom), 1, 1'b0, 1'b0);

        // random frames
        for (int f = 0; f < 12; f++) begin
            if (f % 4 == 3) run_frame(11'($urandom_range(2043, 2047)), $urandom_range(1, 6), 1'b0, 1'b0);
            else            run_frame(11'($urandom), $urandom_range(1, 5), ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
